ram_rd_sched: RTL and testbench
===============================

RAM_RD_SCHED -- requirements
Module: ram_rd_sched

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, RAM read address width.
REQ-002 SHALL have parameter DATA_W, default 8, RAM read data width.
REQ-003 SHALL have parameter LEN_W, default 4, burst length field width; field value = beats-1.
REQ-004 SHALL have port rd_clk  input  1  the single clock for all logic.
REQ-005 SHALL have port rd_rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports m0_req / m1_req  input  1  requester wants a burst; held until its ack.
REQ-007 SHALL have ports m0_addr / m1_addr  input  ADDR_W  burst start address; held with req.
REQ-008 SHALL have ports m0_len / m1_len  input  LEN_W  burst beats-1; held with req.
REQ-009 SHALL have ports m0_ack / m1_ack  output  1  one-cycle pulse on the first issued beat of that requester's burst.
REQ-010 SHALL have ports m0_rvalid / m1_rvalid  output  1  read data valid for that requester.
REQ-011 SHALL have ports m0_rdata / m1_rdata  output  DATA_W  read data; both are driven from ram_rd_data and are meaningful only while the matching rvalid is high.
REQ-012 SHALL have port ram_rd_addr  output  ADDR_W  drives the simple dual-port RAM read address.
REQ-013 SHALL have port ram_rd_en  output  1  high on every beat-issue cycle; intended for RAM read clock enable.
REQ-014 SHALL have port ram_rd_data  input  DATA_W  RAM read data.

Function
REQ-015 SHALL implement FSM states IDLE and BURST.
REQ-016 In IDLE, when at least one req is high at a rising edge, SHALL latch the winner's addr, len and id, and enter BURST.
REQ-017 Arbitration SHALL be two-way round-robin. The last-granted requester has lower priority. After reset, m0 has priority.
REQ-018 In each BURST cycle SHALL assert ram_rd_en, present the current address on ram_rd_addr, increment the address, and decrement the beat counter.
REQ-019 The address SHALL wrap modulo 2^ADDR_W (1023 -> 0 at default).
REQ-020 mX_ack SHALL be high only in the first BURST cycle of requester X's burst.
REQ-021 After the beat with counter = 0 is issued, SHALL return to IDLE. A burst of len+1 beats occupies len+2 cycles, including the arbitration cycle.
REQ-022 A latched burst SHALL complete even if req drops. A req dropped in IDLE before sampling SHALL have no effect.
REQ-023 A req held high after ack SHALL be treated as a new request in the next IDLE cycle, subject to round-robin.
REQ-024 mX_rvalid SHALL assert exactly RD_LAT cycles after each issue cycle, in issue order, routed by a pipelined requester tag. RD_LAT is 1 by default.
REQ-025 The two rvalid outputs SHALL never be high in the same cycle.
REQ-026 ram_rd_addr SHALL hold its last value while in IDLE.

Reset
REQ-027 On rd_rst SHALL enter IDLE and set round-robin priority to m0.
REQ-028 On rd_rst SHALL clear all acks, rvalids, ram_rd_en and the tag pipeline, and set ram_rd_addr to 0.
REQ-029 Reset during a burst SHALL abort it. No rvalid SHALL appear for beats issued before reset.

Configuration
REQ-030 Macro RAM_RD_SCHED_OREG_EN, when defined, SHALL select RD_LAT=2 with a 2-deep tag pipeline, for a RAM built with its output register enabled and OCE tied high.
REQ-031 When RAM_RD_SCHED_OREG_EN is undefined, SHALL use RD_LAT=1 with a 1-deep tag pipeline.

Structure
REQ-032 Package ram_rd_sched_pkg SHALL hold:
- the FSM state typedef (IDLE, BURST);
- default ADDR_W, DATA_W and LEN_W constants;
- the RD_LAT constant derived from the macro.
REQ-033 The round-robin picker SHALL be a sub-module named ram_rr_arb2. Its inputs are req[1:0], priority pointer and advance strobe. Its output is a one-hot grant.

Verification
REQ-034 Scenario: m0 req, addr=0x010, len=3 -> ack on cycle 1, addresses 0x010..0x013 on cycles 1-4, m0_rvalid on cycles 2-5 with RAM contents; m1 stays silent.
REQ-035 Scenario: m0 and m1 req in the same cycle after reset, len=0 each, both held -> m0 served first, then m1, then m0; acks alternate and rvalid routes correctly.
REQ-036 Scenario: m1 addr=0x3FE, len=3 -> ram_rd_addr sequence 0x3FE, 0x3FF, 0x000, 0x001.
REQ-037 Scenario: rd_rst asserted on the third beat of a len=7 burst -> next cycle is IDLE with ram_rd_addr=0; no further rvalid or ack.
REQ-038 Scenario: m0 drops req after ack during a len=5 burst -> all 6 beats issue and 6 rvalids return.
REQ-039 Scenario: with RAM_RD_SCHED_OREG_EN defined, repeat the first scenario -> rvalid on cycles 3-6 and data matches.

Source files
------------

// File: rtl/ram_rd_sched_pkg.sv
// ram_rd_sched_pkg
//   Shared types and constants for the RAM read scheduler.
//   - state_t        : scheduler FSM states (IDLE, BURST)
//   - DEF_ADDR_W/... : default parameter values for ram_rd_sched
//   - RD_LAT         : RAM read latency in cycles; 2 when RAM_RD_SCHED_OREG_EN
//                      is defined (RAM output register enabled, OCE high),
//                      otherwise 1.
package ram_rd_sched_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   localparam int unsigned DEF_ADDR_W = 10;
   localparam int unsigned DEF_DATA_W = 8;
   localparam int unsigned DEF_LEN_W  = 4;

`ifdef RAM_RD_SCHED_OREG_EN
   localparam int unsigned RD_LAT = 2;
`else
   localparam int unsigned RD_LAT = 1;
`endif

endpackage

// File: rtl/ram_rr_arb2.sv
// ram_rr_arb2
//   Two-way round-robin picker (combinational).
//   req_i[1:0] : request vector, bit 0 = m0, bit 1 = m1
//   prio_i     : priority pointer, 0 = m0 preferred, 1 = m1 preferred
//   adv_i      : arbitration strobe; grant is all-zero while low
//   gnt_o[1:0] : one-hot grant
module ram_rr_arb2 (
   input  logic [1:0] req_i,
   input  logic       prio_i,
   input  logic       adv_i,
   output logic [1:0] gnt_o
);

   always_comb begin
      gnt_o = '0;
      if (adv_i) begin
         if (!prio_i) begin
            if (req_i[0])      gnt_o = 2'b01;
            else if (req_i[1]) gnt_o = 2'b10;
         end else begin
            if (req_i[1])      gnt_o = 2'b10;
            else if (req_i[0]) gnt_o = 2'b01;
         end
      end
   end

endmodule

// File: rtl/ram_rd_sched.sv
// ram_rd_sched
//   Schedules read bursts from two requesters onto one simple dual-port RAM
//   read port and routes the returning data back to the issuing requester.
//   Optional build macro: RAM_RD_SCHED_OREG_EN (2-cycle RAM read latency).
//
//   rd_clk, rd_rst          : clock, synchronous active-high reset
//   mX_req/mX_addr/mX_len   : burst request, start address, beats-1 (held until ack)
//   mX_ack                  : pulse on first issued beat of X's burst
//   mX_rvalid/mX_rdata      : returned read data for requester X
//   ram_rd_addr/ram_rd_en   : RAM read address / read clock enable
//   ram_rd_data             : RAM read data
module ram_rd_sched
   import ram_rd_sched_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned LEN_W  = DEF_LEN_W
) (
   input  logic              rd_clk,
   input  logic              rd_rst,
   input  logic              m0_req,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [LEN_W-1:0]  m0_len,
   input  logic              m1_req,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [LEN_W-1:0]  m1_len,
   output logic              m0_ack,
   output logic              m1_ack,
   output logic              m0_rvalid,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [ADDR_W-1:0] ram_rd_addr,
   output logic              ram_rd_en,
   input  logic [DATA_W-1:0] ram_rd_data
);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [LEN_W-1:0]    cnt_q, cnt_d;
   logic                id_q, id_d;
   logic                first_q, first_d;
   logic                prio_q, prio_d;
   logic                arb_adv;
   logic [1:0]          gnt;
   logic [RD_LAT-1:0]   tag_vld_q;
   logic [RD_LAT-1:0]   tag_id_q;

   assign arb_adv = (state_q == IDLE);

   ram_rr_arb2 u_arb (
      .req_i  ({m1_req, m0_req}),
      .prio_i (prio_q),
      .adv_i  (arb_adv),
      .gnt_o  (gnt)
   );

   // State register
   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         id_q    <= 1'b0;
         first_q <= 1'b0;
         prio_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         id_q    <= id_d;
         first_q <= first_d;
         prio_q  <= prio_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      id_d    = id_q;
      first_d = 1'b0;
      prio_d  = prio_q;
      unique case (state_q)
         IDLE: begin
            if (|gnt) begin
               state_d = BURST;
               id_d    = gnt[1];
               addr_d  = gnt[1] ? m1_addr : m0_addr;
               cnt_d   = gnt[1] ? m1_len  : m0_len;
               first_d = 1'b1;
               // Winner drops to lower priority next round.
               prio_d  = gnt[0];
            end
         end
         BURST: begin
            // Address is not advanced past the final beat so it holds in IDLE.
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               addr_d = addr_q + 1'b1;
               cnt_d  = cnt_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      ram_rd_en   = (state_q == BURST);
      ram_rd_addr = addr_q;
      m0_ack      = (state_q == BURST) && first_q && !id_q;
      m1_ack      = (state_q == BURST) && first_q &&  id_q;
      m0_rvalid   = tag_vld_q[RD_LAT-1] && !tag_id_q[RD_LAT-1];
      m1_rvalid   = tag_vld_q[RD_LAT-1] &&  tag_id_q[RD_LAT-1];
      m0_rdata    = ram_rd_data;
      m1_rdata    = ram_rd_data;
   end

   // Requester tag pipeline, aligned with the RAM read latency.
   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         tag_vld_q <= '0;
         tag_id_q  <= '0;
      end else begin
         tag_vld_q[0] <= ram_rd_en;
         tag_id_q[0]  <= id_q;
         for (int unsigned i = 1; i < RD_LAT; i++) begin
            tag_vld_q[i] <= tag_vld_q[i-1];
            tag_id_q[i]  <= tag_id_q[i-1];
         end
      end
   end

endmodule

// File: tb/tb_ram_rd_sched.sv
module tb_ram_rd_sched;

`ifdef RAM_RD_SCHED_OREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic       rd_clk = 1'b0;
   logic       rd_rst;
   logic       m0_req, m1_req;
   logic [9:0] m0_addr, m1_addr;
   logic [3:0] m0_len, m1_len;
   logic       m0_ack, m1_ack, m0_rvalid, m1_rvalid;
   logic [7:0] m0_rdata, m1_rdata;
   logic [9:0] ram_rd_addr;
   logic       ram_rd_en;
   logic [7:0] ram_rd_data;

   int checks = 0;
   int errors = 0;

   always #5 rd_clk = ~rd_clk;

   ram_rd_sched #(.ADDR_W(10), .DATA_W(8), .LEN_W(4)) dut (
      .rd_clk(rd_clk), .rd_rst(rd_rst),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_len(m0_len),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_len(m1_len),
      .m0_ack(m0_ack), .m1_ack(m1_ack),
      .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
      .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
      .ram_rd_addr(ram_rd_addr), .ram_rd_en(ram_rd_en),
      .ram_rd_data(ram_rd_data)
   );

   // RAM contents: a fixed function of the address.
   function automatic logic [7:0] dat(input logic [9:0] a);
      return a[7:0] ^ 8'h5A ^ {6'b0, a[9:8]};
   endfunction

   logic [7:0] q1, q2;
   always @(posedge rd_clk) begin
      if (ram_rd_en) q1 <= dat(ram_rd_addr);
      q2 <= q1;
   end
   assign ram_rd_data = (LAT == 2) ? q2 : q1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      bit         rst;
      bit         r0; logic [9:0] a0; logic [3:0] l0;
      bit         r1; logic [9:0] a1; logic [3:0] l1;
      bit         en; logic [9:0] addr; bit k0; bit k1; bit id;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(bit rst, bit r0, logic [9:0] a0, logic [3:0] l0,
                               bit r1, logic [9:0] a1, logic [3:0] l1,
                               bit en, logic [9:0] addr, bit k0, bit k1, bit id);
      vec_t v;
      v.rst = rst; v.r0 = r0; v.a0 = a0; v.l0 = l0;
      v.r1 = r1; v.a1 = a1; v.l1 = l1;
      v.en = en; v.addr = addr; v.k0 = k0; v.k1 = k1; v.id = id;
      vecs.push_back(v);
   endfunction

   vec_t v, src;
   bit   ok, exp_rv0, exp_rv1, found;
   logic [7:0] exp_dat;
   int   n, rvcnt, beats;

   initial begin
      //   rst r0 a0     l0  r1 a1     l1  en addr   k0 k1 id
      // single m0 burst, len 3
      add(0, 1,'h010,3,  0,'h000,0,  0,'h000,0,0,0);
      add(0, 1,'h010,3,  0,'h000,0,  1,'h010,1,0,0);
      add(0, 0,'h000,0,  0,'h000,0,  1,'h011,0,0,0);
      add(0, 0,'h000,0,  0,'h000,0,  1,'h012,0,0,0);
      add(0, 0,'h000,0,  0,'h000,0,  1,'h013,0,0,0);
      add(0, 0,'h000,0,  0,'h000,0,  0,'h013,0,0,0);
      add(1, 0,'h000,0,  0,'h000,0,  0,'h013,0,0,0);
      // both requesters held, len 0: m0, m1, m0
      add(0, 1,'h020,0,  1,'h030,0,  0,'h000,0,0,0);
      add(0, 1,'h020,0,  1,'h030,0,  1,'h020,1,0,0);
      add(0, 1,'h020,0,  1,'h030,0,  0,'h020,0,0,0);
      add(0, 1,'h020,0,  1,'h030,0,  1,'h030,0,1,1);
      add(0, 1,'h020,0,  1,'h030,0,  0,'h030,0,0,0);
      add(0, 1,'h020,0,  1,'h030,0,  1,'h020,1,0,0);
      add(0, 0,'h000,0,  0,'h000,0,  0,'h020,0,0,0);
      // m1 burst wrapping the address space
      add(0, 0,'h000,0,  1,'h3FE,3,  0,'h020,0,0,0);
      add(0, 0,'h000,0,  1,'h3FE,3,  1,'h3FE,0,1,1);
      add(0, 0,'h000,0,  0,'h000,0,  1,'h3FF,0,0,1);
      add(0, 0,'h000,0,  0,'h000,0,  1,'h000,0,0,1);
      add(0, 0,'h000,0,  0,'h000,0,  1,'h001,0,0,1);
      add(0, 0,'h000,0,  0,'h000,0,  0,'h001,0,0,0);
      // m0 len 5, req dropped after ack
      add(0, 1,'h100,5,  0,'h000,0,  0,'h001,0,0,0);
      add(0, 1,'h100,5,  0,'h000,0,  1,'h100,1,0,0);
      add(0, 0,'h000,0,  0,'h000,0,  1,'h101,0,0,0);
      add(0, 0,'h000,0,  0,'h000,0,  1,'h102,0,0,0);
      add(0, 0,'h000,0,  0,'h000,0,  1,'h103,0,0,0);
      add(0, 0,'h000,0,  0,'h000,0,  1,'h104,0,0,0);
      add(0, 0,'h000,0,  0,'h000,0,  1,'h105,0,0,0);
      add(0, 0,'h000,0,  0,'h000,0,  0,'h105,0,0,0);
      add(0, 0,'h000,0,  0,'h000,0,  0,'h105,0,0,0);
      // m0 len 7, reset on third beat
      add(0, 1,'h200,7,  0,'h000,0,  0,'h105,0,0,0);
      add(0, 1,'h200,7,  0,'h000,0,  1,'h200,1,0,0);
      add(0, 0,'h000,0,  0,'h000,0,  1,'h201,0,0,0);
      add(1, 0,'h000,0,  0,'h000,0,  1,'h202,0,0,0);
      add(0, 0,'h000,0,  0,'h000,0,  0,'h000,0,0,0);
      // priority back to m0 after reset
      add(0, 1,'h040,0,  1,'h050,0,  0,'h000,0,0,0);
      add(0, 1,'h040,0,  1,'h050,0,  1,'h040,1,0,0);
      add(0, 0,'h000,0,  1,'h050,0,  0,'h040,0,0,0);
      add(0, 0,'h000,0,  1,'h050,0,  1,'h050,0,1,1);
      add(0, 0,'h000,0,  0,'h000,0,  0,'h050,0,0,0);
      add(0, 0,'h000,0,  0,'h000,0,  0,'h050,0,0,0);

      rd_rst = 1'b1;
      m0_req = 1'b0; m0_addr = '0; m0_len = '0;
      m1_req = 1'b0; m1_addr = '0; m1_len = '0;
      repeat (3) @(posedge rd_clk);
      #1 rd_rst = 1'b0;
      @(negedge rd_clk);
      chk("reset en",      ram_rd_en,   0);
      chk("reset addr",    ram_rd_addr, 0);
      chk("reset acks",    {m0_ack, m1_ack}, 0);
      chk("reset rvalids", {m0_rvalid, m1_rvalid}, 0);
      @(posedge rd_clk); #1;

      for (int t = 0; t < vecs.size(); t++) begin
         v = vecs[t];
         rd_rst = v.rst;
         m0_req = v.r0; m0_addr = v.a0; m0_len = v.l0;
         m1_req = v.r1; m1_addr = v.a1; m1_len = v.l1;
         @(negedge rd_clk);
         exp_rv0 = 1'b0; exp_rv1 = 1'b0; exp_dat = '0;
         if (t >= LAT) begin
            src = vecs[t-LAT];
            ok = src.en;
            for (int k = t - LAT; k < t; k++) if (vecs[k].rst) ok = 1'b0;
            if (ok) begin
               if (src.id) exp_rv1 = 1'b1; else exp_rv0 = 1'b0 | 1'b1;
               exp_dat = dat(src.addr);
            end
         end
         chk($sformatf("row %0d ram_rd_en", t),   ram_rd_en,   v.en);
         chk($sformatf("row %0d ram_rd_addr", t), ram_rd_addr, v.addr);
         chk($sformatf("row %0d m0_ack", t),      m0_ack,      v.k0);
         chk($sformatf("row %0d m1_ack", t),      m1_ack,      v.k1);
         chk($sformatf("row %0d m0_rvalid", t),   m0_rvalid,   exp_rv0);
         chk($sformatf("row %0d m1_rvalid", t),   m1_rvalid,   exp_rv1);
         if (exp_rv0) chk($sformatf("row %0d m0_rdata", t), m0_rdata, exp_dat);
         if (exp_rv1) chk($sformatf("row %0d m1_rdata", t), m1_rdata, exp_dat);
         @(posedge rd_clk); #1;
      end
      rd_rst = 1'b0;

      // A request pulse that never spans a rising edge has no effect.
      m1_req = 1'b1; m1_addr = 10'h077; m1_len = 4'd1;
      #2 m1_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge rd_clk);
         chk($sformatf("glitch %0d en/acks", i), {ram_rd_en, m0_ack, m1_ack}, 0);
         @(posedge rd_clk); #1;
      end

      // m1 len 2: bounded wait for ack, then count beats and returned data.
      m1_req = 1'b1; m1_addr = 10'h0AA; m1_len = 4'd2;
      found = 1'b0; n = 0;
      while (!found && n < 6) begin
         @(negedge rd_clk);
         n++;
         if (m1_ack) found = 1'b1;
         else begin @(posedge rd_clk); #1; end
      end
      chk("m1 ack within bound", found, 1);
      if (found) begin
         chk("m1 first addr", ram_rd_addr, 10'h0AA);
         beats = ram_rd_en ? 1 : 0;
         rvcnt = m1_rvalid ? 1 : 0;
         for (int i = 0; i < 7; i++) begin
            @(posedge rd_clk); #1;
            m1_req = 1'b0;
            @(negedge rd_clk);
            if (ram_rd_en) beats++;
            if (m1_rvalid) rvcnt++;
            if (m0_rvalid) chk("m0 silent", m0_rvalid, 0);
         end
         chk("m1 beats", beats, 3);
         chk("m1 rvalid count", rvcnt, 3);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
